// File: rtl/alu_seq.sv
`default_nettype none
// alu_seq: single-cycle ALU with an iterative shift-add multiplier (Rev 1.0).
// Results and flags are registered; out_valid pulses one cycle per result.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dst,
  output logic             zflag,
  output logic             cflag,
  output logic             nflag,
  output logic             vflag,
  output logic             out_valid
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  localparam int               CW      = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;

  logic [WIDTH-1:0]   res;
  logic               c_res;
  logic               v_res;
  logic               wr_dst;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               big_shift;
  logic [2*WIDTH-1:0] acc_next;

  assign in_ready = (state == IDLE) && !rst;
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    sum       = {1'b0, srca} + {1'b0, srcb};
    diff      = {1'b0, srca} - {1'b0, srcb};
    big_shift = (srcb >= WIDTH_V);
    res       = '0;
    c_res     = 1'b0;
    v_res     = 1'b0;
    wr_dst    = 1'b1;
    case (op)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        c_res = sum[WIDTH];
        v_res = (srca[WIDTH-1] == srcb[WIDTH-1]) && (res[WIDTH-1] != srca[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        // diff[WIDTH] is the borrow, i.e. srca < srcb unsigned
        res    = diff[WIDTH-1:0];
        c_res  = diff[WIDTH];
        v_res  = (srca[WIDTH-1] != srcb[WIDTH-1]) && (res[WIDTH-1] != srca[WIDTH-1]);
        wr_dst = (op != OP_CMP);
      end
      OP_AND:  res = srca & srcb;
      OP_OR:   res = srca | srcb;
      OP_XOR:  res = srca ^ srcb;
      OP_NOT:  res = ~srca;
      OP_SLL:  res = big_shift ? '0 : (srca << srcb);
      OP_SRL:  res = big_shift ? '0 : (srca >> srcb);
      OP_SRA:  res = big_shift ? {WIDTH{srca[WIDTH-1]}} : WIDTH'($signed(srca) >>> srcb);
      OP_PASS: res = srcb;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      dst       <= '0;
      zflag     <= 1'b0;
      cflag     <= 1'b0;
      nflag     <= 1'b0;
      vflag     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              state  <= MUL;
              cnt    <= '0;
              mcand  <= {{WIDTH{1'b0}}, srca};
              mplier <= srcb;
              acc    <= '0;
            end else begin
              if (wr_dst) dst <= res;
              zflag     <= (res == '0);
              cflag     <= c_res;
              nflag     <= res[WIDTH-1];
              vflag     <= v_res;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          // One multiplier bit per edge; the last edge also publishes the result.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= IDLE;
            dst       <= acc_next[WIDTH-1:0];
            zflag     <= (acc_next[WIDTH-1:0] == '0);
            cflag     <= (acc_next[2*WIDTH-1:WIDTH] != '0);
            nflag     <= acc_next[WIDTH-1];
            vflag     <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// tb_alu_seq: directed table, corner sequences and randomized checks of alu_seq
// at WIDTH=8 and WIDTH=16 against a behavioural arithmetic model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  op = 4'd0;
  logic [15:0] srca = 16'd0;
  logic [15:0] srcb = 16'd0;
  logic        iv8 = 1'b0;
  logic        iv16 = 1'b0;
  bit          sel16 = 1'b0;

  logic        d8_rdy, d8_z, d8_c, d8_n, d8_v, d8_ov;
  logic [7:0]  d8_dst;
  logic        d16_rdy, d16_z, d16_c, d16_n, d16_v, d16_ov;
  logic [15:0] d16_dst;

  logic [15:0] o_dst;
  logic        o_rdy, o_z, o_c, o_n, o_v, o_ov;

  int checks = 0;
  int errors = 0;
  longint prev8 = 0;
  longint prev16 = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .op(op), .srca(srca[7:0]), .srcb(srcb[7:0]),
    .in_valid(iv8), .in_ready(d8_rdy), .dst(d8_dst), .zflag(d8_z),
    .cflag(d8_c), .nflag(d8_n), .vflag(d8_v), .out_valid(d8_ov)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .op(op), .srca(srca), .srcb(srcb),
    .in_valid(iv16), .in_ready(d16_rdy), .dst(d16_dst), .zflag(d16_z),
    .cflag(d16_c), .nflag(d16_n), .vflag(d16_v), .out_valid(d16_ov)
  );

  always_comb begin
    if (sel16) begin
      o_dst = d16_dst; o_rdy = d16_rdy; o_z = d16_z; o_c = d16_c;
      o_n = d16_n; o_v = d16_v; o_ov = d16_ov;
    end else begin
      o_dst = {8'h00, d8_dst}; o_rdy = d8_rdy; o_z = d8_z; o_c = d8_c;
      o_n = d8_n; o_v = d8_v; o_ov = d8_ov;
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] dst;
    bit          z, c, n, v;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: values treated as plain integers, signed view for overflow.
  task automatic model(input int w, input logic [3:0] o, input longint a, input longint b,
                       input longint prev, output longint edst,
                       output bit z, output bit c, output bit n, output bit v);
    longint mask, half, sa, sb, t, r, p;
    mask = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    sa = (a >= half) ? a - (64'sd1 <<< w) : a;
    sb = (b >= half) ? b - (64'sd1 <<< w) : b;
    r = 0; c = 0; v = 0;
    case (o)
      4'd0: begin
        r = (a + b) & mask; c = (a + b) > mask;
        t = sa + sb; v = (t < -half) || (t >= half);
      end
      4'd1, 4'd10: begin
        r = (a - b) & mask; c = a < b;
        t = sa - sb; v = (t < -half) || (t >= half);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (~a) & mask;
      4'd6: r = (b >= w) ? 0 : (a << b) & mask;
      4'd7: r = (b >= w) ? 0 : a >> b;
      4'd8: r = ((b >= w) ? ((sa < 0) ? -1 : 0) : (sa >>> b)) & mask;
      4'd9: begin p = a * b; r = p & mask; c = p > mask; end
      4'd11: r = b;
      default: r = 0;
    endcase
    z = (r == 0);
    n = ((r >> (w - 1)) & 1) != 0;
    edst = (o == 4'd10) ? prev : r;
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input bit wide, input logic [15:0] edst,
                       input bit ez, input bit ec, input bit en, input bit ev, input string tag);
    int w, n, lowcnt, expn;
    w = wide ? 16 : 8;
    expn = (o == 4'd9) ? w : 0;
    sel16 = wide;
    for (int k = 0; k < 50 && !o_rdy; k++) begin @(posedge clk); #1; end
    check({tag, " ready"}, o_rdy, 1);
    op = o; srca = a; srcb = b; iv8 = !wide; iv16 = wide;
    @(posedge clk); #1;
    iv8 = 0; iv16 = 0;
    if (o == 4'd9) begin
      // Unrelated requests offered while busy must be ignored.
      op = 4'd0; srca = 16'h1; srcb = 16'h1; iv8 = !wide; iv16 = wide;
    end
    n = 0; lowcnt = 0;
    while (!o_ov && n <= w + 4) begin
      if (!o_rdy) lowcnt++;
      @(posedge clk); #1;
      n++;
    end
    iv8 = 0; iv16 = 0;
    check({tag, " latency"}, n, expn);
    if (o == 4'd9) check({tag, " ready_low_cycles"}, lowcnt, w);
    check({tag, " dst"}, o_dst, edst);
    check({tag, " zflag"}, o_z, ez);
    check({tag, " cflag"}, o_c, ec);
    check({tag, " nflag"}, o_n, en);
    check({tag, " vflag"}, o_v, ev);
  endtask

  task automatic rand_run(input bit wide, input int count);
    int w;
    longint mask, a, b, prev, edst;
    bit z, c, n, v;
    logic [3:0] o;
    w = wide ? 16 : 8;
    mask = (64'sd1 <<< w) - 1;
    for (int i = 0; i < count; i++) begin
      o = 4'($urandom_range(0, 15));
      a = longint'($urandom) & mask;
      b = longint'($urandom) & mask;
      if (o >= 4'd6 && o <= 4'd8) b = longint'($urandom_range(0, w + 3));
      if ($urandom_range(0, 7) == 0) b = a;
      prev = wide ? prev16 : prev8;
      model(w, o, a, b, prev, edst, z, c, n, v);
      issue(o, 16'(a), 16'(b), wide, 16'(edst), z, c, n, v,
            $sformatf("rand%0d_w%0d_op%0d", i, w, o));
      if (wide) prev16 = edst; else prev8 = edst;
    end
  endtask

  initial begin
    int ovseen;
    vecs[0]  = '{4'd0,  16'd200,  16'd100, 16'd44,   0, 1, 0, 0};
    vecs[1]  = '{4'd1,  16'd5,    16'd5,   16'd0,    1, 0, 0, 0};
    vecs[2]  = '{4'd1,  16'd3,    16'd5,   16'd254,  0, 1, 1, 0};
    vecs[3]  = '{4'd0,  16'd100,  16'd100, 16'd200,  0, 0, 1, 1};
    vecs[4]  = '{4'd9,  16'd15,   16'd17,  16'd255,  0, 0, 1, 0};
    vecs[5]  = '{4'd9,  16'd16,   16'd16,  16'd0,    1, 1, 0, 0};
    vecs[6]  = '{4'd6,  16'h01,   16'd7,   16'h80,   0, 0, 1, 0};
    vecs[7]  = '{4'd7,  16'hFF,   16'd8,   16'h00,   1, 0, 0, 0};
    vecs[8]  = '{4'd8,  16'h80,   16'd9,   16'hFF,   0, 0, 1, 0};
    vecs[9]  = '{4'd10, 16'd7,    16'd7,   16'hFF,   1, 0, 0, 0};
    vecs[10] = '{4'd13, 16'd3,    16'd4,   16'd0,    1, 0, 0, 0};
    vecs[11] = '{4'd11, 16'd9,    16'h5A,  16'h5A,   0, 0, 0, 0};
    vecs[12] = '{4'd2,  16'hF3,   16'h3C,  16'h30,   0, 0, 0, 0};
    vecs[13] = '{4'd5,  16'h0F,   16'd0,   16'hF0,   0, 0, 1, 0};

    #12;
    check("reset dst", d8_dst, 0);
    check("reset flags", {d8_z, d8_c, d8_n, d8_v}, 0);
    check("reset out_valid", d8_ov, 0);
    check("reset in_ready", d8_rdy, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check("post-reset in_ready", d8_rdy, 1);
    check("post-reset out_valid", d8_ov, 0);

    foreach (vecs[i])
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].dst,
            vecs[i].z, vecs[i].c, vecs[i].n, vecs[i].v, $sformatf("vec%0d", i));
    prev8 = 16'hF0;

    @(posedge clk); #1;
    check("pulse out_valid drop", o_ov, 0);
    check("hold dst", o_dst, 16'hF0);
    check("hold nflag", o_n, 1);

    // Reset three edges into a multiply.
    sel16 = 0;
    op = 4'd9; srca = 16'd15; srcb = 16'd17; iv8 = 1;
    @(posedge clk); #1; iv8 = 0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1; #1;
    check("abort dst", o_dst, 0);
    check("abort flags", {o_z, o_c, o_n, o_v}, 0);
    check("abort out_valid", o_ov, 0);
    check("abort in_ready", o_rdy, 0);
    @(posedge clk); #1;
    @(posedge clk); #2; rst = 0; #1;
    check("abort release in_ready", o_rdy, 1);
    ovseen = 0;
    repeat (12) begin @(posedge clk); #1; if (o_ov) ovseen++; end
    check("abort no out_valid", ovseen, 0);
    prev8 = 0; prev16 = 0;

    rand_run(1'b0, 150);

    issue(4'd0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1, 1, 0, 0, "w16 add");
    issue(4'd9, 16'd300, 16'd200, 1'b1, 16'hEA60, 0, 0, 1, 0, "w16 mul");
    issue(4'd9, 16'h0100, 16'h0100, 1'b1, 16'h0000, 1, 1, 0, 0, "w16 mul wrap");
    prev16 = 0;
    rand_run(1'b1, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal WIDTH >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port op  input  4  operation code, sampled on the accepting edge.
REQ-005 SHALL have ports srca and srcb, each input, WIDTH bits, operands sampled on the accepting edge.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request (combinational, = state IDLE and not rst).
REQ-008 SHALL have port dst  output  WIDTH  registered result.
REQ-009 SHALL have ports zflag, cflag, nflag and vflag, each output, 1 bit, registered zero/carry/negative/overflow flags.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse marking new dst/flags.

Function
REQ-011 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1; all other cycles ignore op/srca/srcb.
REQ-012 SHALL implement FSM states IDLE and MUL: IDLE->MUL on accepting MUL; MUL->IDLE after WIDTH cycles; all other accepted ops stay in IDLE.
REQ-013 SHALL decode op: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SLL a<<b, 7 SRL a>>b, 8 SRA a>>>b, 9 MUL low WIDTH bits of a*b, 10 CMP a-b (flags only), 11 PASS b, 12-15 reserved.
REQ-014 SHALL, for single-cycle ops, update dst/flags on the accepting edge and raise out_valid for exactly the following cycle; back-to-back accepts every cycle are allowed.
REQ-015 SHALL, for MUL, latch operands, compute by iterative shift-add one bit per cycle, hold in_ready=0 while in MUL, and update dst/flags with out_valid pulse on the WIDTH-th edge after the accepting edge.
REQ-016 SHALL treat shift amount as full unsigned srcb: amount >= WIDTH gives 0 for SLL/SRL and all-sign-bits for SRA.
REQ-017 SHALL set zflag = (result == 0); for CMP, result is a-b and dst holds its previous value.
REQ-018 SHALL set cflag: ADD carry-out; SUB/CMP borrow (a < b unsigned); MUL 1 if upper WIDTH product bits nonzero; else 0.
REQ-019 SHALL set nflag = result MSB, and vflag = signed overflow for ADD/SUB/CMP, else 0.
REQ-020 SHALL, for reserved ops, produce dst=0, zflag=1, other flags 0, with normal single-cycle out_valid.
REQ-021 SHALL hold dst and flags unchanged between results; out_valid=0 when no result completes.

Reset
REQ-022 SHALL, while rst=1, immediately force dst=0, all flags 0, out_valid=0, in_ready=0, state IDLE, and discard MUL progress.
REQ-023 SHALL, on reset mid-MUL, never emit out_valid for the aborted op; in_ready=1 on the first cycle after rst deasserts.

Verification
REQ-024 SHALL be verified at WIDTH=8: ADD 200+100 -> dst=44, cflag=1, zflag=0, out_valid high the cycle after accept only.
REQ-025 SHALL be verified: SUB 5-5 -> dst=0, zflag=1, cflag=0; SUB 3-5 -> dst=254, cflag=1, nflag=1; ADD 100+100 -> dst=200, vflag=1, nflag=1.
REQ-026 SHALL be verified: MUL 15*17 -> in_ready low 8 cycles, dst=255, cflag=0 on 8th edge; MUL 16*16 -> dst=0, zflag=1, cflag=1; in_valid during MUL ignored.
REQ-027 SHALL be verified: SLL 0x01 by 7 -> 0x80; SRL 0xFF by 8 -> 0x00; SRA 0x80 by 9 -> 0xFF; CMP 7,7 -> zflag=1, dst unchanged.
REQ-028 SHALL be verified: rst asserted 3 cycles into MUL -> outputs 0 asynchronously, no out_valid, in_ready=1 after release.
REQ-029 SHALL be verified at WIDTH=16: ADD 0xFFFF+1 -> dst=0, zflag=1, cflag=1; MUL latency 16 cycles.
